mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
// - Shares one combinational 4x4 unsigned multiplier (p = m * q) among N_REQ requesters.
// - Each requester presents an operand pair with valid/ready. The block grants one requester
//   round-robin, registers its operands and the product, and returns the result with a
//   valid/ready response carrying the requester ID.
// - Sits between client FSMs and the shared multiplier. One transaction is in flight at a time.
// PARAMETERS
// - N_REQ  4  number of requesters (2..8)
// - ID_W   2  requester ID width; must equal clog2(N_REQ)
// PORTS
// - clk        in   1          rising-edge clock
// - rst_n      in   1          asynchronous active-low reset
// - req_valid  in   N_REQ      request i holds a valid operand pair
// - req_m      in   4*N_REQ    multiplicand of requester i is req_m[4i+3:4i]
// - req_q      in   4*N_REQ    multiplier of requester i is req_q[4i+3:4i]
// - req_ready  out  N_REQ      one-hot accept; request i transfers when req_valid[i] & req_ready[i]
// - rsp_valid  out  1          result valid
// - rsp_ready  in   1          consumer accepts result
// - rsp_p      out  8          product m*q, unsigned, full width (max 15*15=225, no overflow)
// - rsp_id     out  ID_W       index of the requester that owns rsp_p
// - busy       out  1          high in any state other than IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, rr_ptr=0; req_ready=0, rsp_valid=0, rsp_p=0, rsp_id=0, busy=0.
// - FSM states: IDLE -> CALC -> RESP -> IDLE.
//   - IDLE: req_ready is combinational. It is one-hot at the first asserted req_valid found by
//     searching from rr_ptr upward, modulo N_REQ. If no req_valid is asserted, req_ready=0.
//     On a transfer: latch m, q and id into op regs, set rr_ptr = (granted id + 1) mod N_REQ,
//     go to CALC.
//   - CALC: one cycle. rsp_p <= op_m*op_q, rsp_id <= op_id, rsp_valid <= 1, go to RESP.
//     req_ready=0.
//   - RESP: hold rsp_valid, rsp_p and rsp_id stable until rsp_ready=1. On that handshake
//     cycle: rsp_valid <= 0, go to IDLE. req_ready=0.
// - Latency: request handshake at cycle T -> rsp_valid high from T+2.
//   Minimum spacing between grants is 3 cycles.
// - Response hold: rsp_p and rsp_id are not modified while rsp_valid=1.
//   Outside RESP, rsp_p and rsp_id retain their last values.
// - Fairness: with all requesters asserted continuously, grants cycle 0,1,2,...,N_REQ-1,0.
//   A requester waits at most N_REQ-1 grants.
// - Requesters may drop req_valid while not granted; the arbiter does not capture any state for
//   ungranted requests. Operands are sampled only on the handshake cycle.
// - Simultaneous events: rsp_ready asserted in CALC has no effect.
//   A request in the same cycle as the RESP handshake is not granted until the next IDLE cycle.
// - rsp_ready held high: throughput is one result per 3 cycles.
// - Reset mid-operation: the in-flight transaction is discarded, outputs return to reset
//   values, and no partial response is issued.
// - rr_ptr wraps modulo N_REQ. Out-of-range values (N_REQ not a power of two) are never reached.
// STRUCTURE
// - Shared package mult_share_pkg:
//   - state enum {IDLE, CALC, RESP}
//   - OP_W=4 and P_W=8 constants
//   - function rr_pick(valid, ptr) returning a one-hot grant
// - Sub-module rr_grant: combinational round-robin picker, inputs valid[N_REQ] and ptr[ID_W],
//   outputs gnt[N_REQ] and gnt_id[ID_W].
// - The multiply is a single m*q expression on the op regs; no separate sequencing logic.
// TESTING
// - Reset/idle: rst_n=0 then 1, no requests -> all outputs 0, busy=0, req_ready=0 for 10 cycles.
// - Single request: req 2, m=15, q=15 at T, rsp_ready=1 -> rsp_valid at T+2, rsp_p=225,
//   rsp_id=2, busy falls at T+3.
// - Round-robin: all 4 requesters valid, requester i uses m=i+1, q=3 -> grant order 0,1,2,3,0.
//   Products 3,6,9,12.
// - Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_p and rsp_id stable.
//   No req_ready during the stall. Release -> IDLE next cycle.
// - Reset mid-flight: assert rst_n=0 during CALC with m=7, q=9 -> no rsp_valid, rsp_p=0 after
//   release. A subsequent grant comes from requester 0.
// - Edge operands: m=0,q=9 -> 0; m=1,q=1 -> 1; m=8,q=2 -> 16.
//   Random sweep of all 256 pairs checked against m*q.

Source files
------------

// File: rtl/mult_share_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_pkg
// Brief    : Shared types, widths and round-robin pick function for the
//            shared-multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mult_share_pkg;

    localparam int OP_W     = 4;
    localparam int P_W      = 8;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One-hot grant to the first valid bit found from ptr upward, modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int unsigned         n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int unsigned        idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && valid[idx[MAX_ID_W-1:0]]) begin
                gnt[idx[MAX_ID_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant
// Brief    : Combinational round-robin picker returning a one-hot grant and
//            its encoded index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

    logic [MAX_REQ-1:0]  w_valid_ext;
    logic [MAX_ID_W-1:0] w_ptr_ext;
    logic [MAX_REQ-1:0]  w_pick;
    logic                w_unused_pick;

    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[N_REQ-1:0]   = valid;
        w_ptr_ext                = '0;
        w_ptr_ext[ID_W-1:0]      = ptr;
    end

    assign w_pick        = rr_pick(w_valid_ext, w_ptr_ext, N_REQ);
    assign gnt           = w_pick[N_REQ-1:0];
    assign w_unused_pick = ^w_pick;

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Brief    : Round-robin arbiter sharing one 4x4 unsigned multiplier among
//            N_REQ requesters, one transaction in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [OP_W*N_REQ-1:0] req_m,
    input  logic [OP_W*N_REQ-1:0] req_q,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [P_W-1:0]        rsp_p,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_op_id;
    logic [OP_W-1:0]   r_op_m;
    logic [OP_W-1:0]   r_op_q;

    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_gnt_id;
    logic [ID_W-1:0]   w_ptr_next;
    logic [OP_W-1:0]   w_sel_m;
    logic [OP_W-1:0]   w_sel_q;
    logic              w_xfer;

    rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .valid  (req_valid),
        .ptr    (r_rr_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign req_ready  = (r_state == IDLE) ? w_gnt : '0;
    assign w_xfer     = |(req_valid & req_ready);
    assign busy       = (r_state != IDLE);
    assign w_ptr_next = (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

    always_comb begin
        w_sel_m = '0;
        w_sel_q = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_sel_m = req_m[i*OP_W +: OP_W];
                w_sel_q = req_q[i*OP_W +: OP_W];
            end
        end
    end

    // rsp_p/rsp_id are only written in CALC, so they hold through RESP and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_op_id   <= '0;
            r_op_m    <= '0;
            r_op_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_p     <= '0;
            rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_op_m   <= w_sel_m;
                        r_op_q   <= w_sel_q;
                        r_op_id  <= w_gnt_id;
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_p     <= P_W'(r_op_m) * P_W'(r_op_q);
                    rsp_id    <= r_op_id;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arbiter
// Brief    : Scoreboard bench for mult_share_arbiter; directed vectors push
//            expected responses, a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_REQ-1:0]  req_valid;
    logic [4*N_REQ-1:0] req_m;
    logic [4*N_REQ-1:0] req_q;
    logic [N_REQ-1:0]  req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_p;
    logic [ID_W-1:0]   rsp_id;
    logic              busy;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_m     (req_m),
        .req_q     (req_q),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Response monitor: every accepted response must match the queue head.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_expected", 32'(0), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e[9:8]));
                    chk("rsp_p", 32'(rsp_p), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic wait_ready(input int id, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready[id] !== 1'b1 && n < 30);
        chk(name, 32'(req_ready[id]), 32'(1));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 30);
        chk(name, 32'(busy), 32'(0));
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid !== 1'b1 && n < 30);
        chk(name, 32'(rsp_valid), 32'(1));
    endtask

    task automatic run_one(input int id, input int m, input int q, input int e);
        @(posedge clk);
        #1;
        req_m[id*4 +: 4] = 4'(m);
        req_q[id*4 +: 4] = 4'(q);
        req_valid        = '0;
        req_valid[id]    = 1'b1;
        wait_ready(id, "op_grant");
        exp_q.push_back({2'(id), 8'(e)});
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle("op_idle");
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach end, got running expected finished");
        $fatal(1);
    end

    initial begin
        int gid;
        rst_n     = 1'b0;
        req_valid = '0;
        req_m     = '0;
        req_q     = '0;
        rsp_ready = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", 32'({req_ready, rsp_valid, rsp_p, rsp_id, busy}), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", 32'({req_ready, rsp_valid, rsp_p, rsp_id, busy}), 32'(0));
        end

        // Single request: requester 2, 15*15
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_m[11:8] = 4'd15;
        req_q[11:8] = 4'd15;
        req_valid   = 4'b0100;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'(4'b0100));
        exp_q.push_back({2'd2, 8'd225});
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("single_calc_valid", 32'(rsp_valid), 32'(0));
        chk("single_calc_busy", 32'(busy), 32'(1));
        @(negedge clk);
        chk("single_t2_valid", 32'(rsp_valid), 32'(1));
        @(negedge clk);
        chk("single_t3_busy", 32'(busy), 32'(0));
        chk("single_t3_valid", 32'(rsp_valid), 32'(0));

        // Backpressure: requester 1, 5*6, then a waiting request from 0
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_m[7:4] = 4'd5;
        req_q[7:4] = 4'd6;
        req_valid  = 4'b0010;
        wait_ready(1, "bp_grant");
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp("bp_rsp");
        exp_q.push_back({2'd1, 8'd30});
        req_m[3:0] = 4'd2;
        req_q[3:0] = 4'd7;
        req_valid  = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
            chk("bp_hold_p", 32'(rsp_p), 32'(30));
            chk("bp_hold_id", 32'(rsp_id), 32'(1));
            chk("bp_no_ready", 32'(req_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_busy", 32'(busy), 32'(0));
        chk("bp_release_ready", 32'(req_ready), 32'(4'b0001));
        exp_q.push_back({2'd0, 8'd14});
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle("bp_idle");

        // Reset during CALC: requester 3, 7*9, must never respond
        @(posedge clk);
        #1;
        req_m[15:12] = 4'd7;
        req_q[15:12] = 4'd9;
        req_valid    = 4'b1000;
        wait_ready(3, "mf_grant");
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("mf_rst_outs", 32'({req_ready, rsp_valid, rsp_p, rsp_id, busy}), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mf_no_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("mf_rsp_p_zero", 32'(rsp_p), 32'(0));
        end

        // Round-robin from a fresh pointer: grants 0,1,2,3,0
        @(posedge clk);
        #1;
        req_m     = {4'd4, 4'd3, 4'd2, 4'd1};
        req_q     = {4'd3, 4'd3, 4'd3, 4'd3};
        req_valid = 4'b1111;
        exp_q.push_back({2'd0, 8'd3});
        exp_q.push_back({2'd1, 8'd6});
        exp_q.push_back({2'd2, 8'd9});
        exp_q.push_back({2'd3, 8'd12});
        exp_q.push_back({2'd0, 8'd3});
        for (int g = 0; g < 5; g++) begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while ((req_valid & req_ready) == '0 && n < 30);
            gid = -1;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) gid = i;
            end
            chk("rr_order", 32'(gid), 32'(g % 4));
            @(posedge clk);
            #1;
            if (g == 4) req_valid = '0;
        end
        wait_idle("rr_idle");

        // Edge operands
        run_one(0, 0, 9, 0);
        run_one(1, 1, 1, 1);
        run_one(2, 8, 2, 16);

        // Full operand sweep
        for (int m = 0; m < 16; m++) begin
            for (int q = 0; q < 16; q++) begin
                run_one((m + q) % 4, m, q, m * q);
            end
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
